// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and everything that talks to it.
//   - ALU operation codes carried on ctrl_in / req_ctrl
//   - bit positions inside the 4-bit flag bundle {branch, ZF, OF, CF}
//   - state encoding of the ALU share arbiter
// No ports; imported with "import alu_pkg::*;".
// ---------------------------------------------------------------------------
package alu_pkg;

    // ALU operation codes. Bit 3 set means a compare/branch operation.
    localparam logic [3:0] ADD   = 4'b0000;
    localparam logic [3:0] SLL   = 4'b0001;
    localparam logic [3:0] SLTI  = 4'b0010;
    localparam logic [3:0] SLTIU = 4'b0011;
    localparam logic [3:0] XOR   = 4'b0100;
    localparam logic [3:0] SRI   = 4'b0101;
    localparam logic [3:0] OR    = 4'b0110;
    localparam logic [3:0] AND   = 4'b0111;
    localparam logic [3:0] BEQ   = 4'b1000;
    localparam logic [3:0] BNE   = 4'b1001;
    localparam logic [3:0] BLT   = 4'b1100;
    localparam logic [3:0] BGE   = 4'b1101;
    localparam logic [3:0] BLTU  = 4'b1110;
    localparam logic [3:0] BGEU  = 4'b1111;

    // Bit indices inside the flag bundle {branch, ZF, OF, CF}.
    localparam int BR = 3;
    localparam int ZF = 2;
    localparam int OF = 1;
    localparam int CF = 0;

    // Arbiter states.
    //   IDLE : nothing outstanding, arbitration is live
    //   WAIT : one operation issued, its result not yet consumed
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

endpackage : alu_pkg

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Picks the first asserted request
// starting at rr_ptr and moving upward, wrapping modulo NREQ. Holds no state;
// the owner of the pointer decides when and how it advances, which keeps this
// block reusable for other shared-port arbiters.
//
// Parameters
//   NREQ : number of requesters
//   OWW  : width of rr_ptr / grant_idx
// Ports
//   req       in   NREQ  request vector
//   rr_ptr    in   OWW   highest-priority requester this cycle (< NREQ)
//   grant     out  NREQ  one-hot grant, all zero when req is zero
//   grant_idx out  OWW   index of the granted requester, 0 when req is zero
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int OWW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [OWW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [OWW-1:0]  grant_idx
);

    // Walk the offsets from the farthest to the nearest; the last hit wins,
    // so the requester closest to rr_ptr ends up holding the grant.
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the unassigned paths infer latches.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx = (int'(rr_ptr) + off) % NREQ;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = OWW'(idx);
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one ALU between NREQ requesters (e.g. EXU operand path and the
// branch/address-generation path). Round-robin arbitration picks a winner
// combinationally, its operands go straight to the ALU input handshake, and
// the single outstanding result is steered back to the owner only. A flush
// (jump) is forwarded to the ALU and kills any in-flight result.
//
// Parameters
//   NREQ : number of requesters (2..4)
//   OWW  : owner/pointer width, clog2(NREQ) with a minimum of 1
// Ports
//   clock, reset        clock and synchronous active-high reset
//   flush               pipeline jump; forwarded as alu_flush
//   req_valid/req_ready per-requester issue handshake
//   req_a, req_b        packed operands, requester i at [32i+31:32i]
//   req_ctrl            packed 4-bit op codes, requester i at [4i+3:4i]
//   req_sub/sign/arch   per-requester ALU modifier bits
//   resp_valid/ready    per-requester result handshake (owner bit only)
//   resp_result/flags   ALU result and {branch,ZF,OF,CF}, broadcast
//   alu_*               the ALU side: input handshake + operands, output
//                       handshake + result/flags, and alu_flush
// ---------------------------------------------------------------------------
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int OWW  = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,

    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*4-1:0]    req_ctrl,
    input  logic [NREQ-1:0]      req_sub,
    input  logic [NREQ-1:0]      req_sign,
    input  logic [NREQ-1:0]      req_arch,

    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [31:0]          resp_result,
    output logic [3:0]           resp_flags,

    output logic                 alu_in_valid,
    input  logic                 alu_in_ready,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [3:0]           alu_ctrl,
    output logic                 alu_sub,
    output logic                 alu_sign,
    output logic                 alu_arch,
    input  logic                 alu_out_valid,
    output logic                 alu_out_ready,
    input  logic [31:0]          alu_result,
    input  logic [3:0]           alu_flags,
    output logic                 alu_flush
);

    logic [0:0]      state;
    logic [OWW-1:0]  rr_ptr;
    logic [OWW-1:0]  owner;
    logic [OWW-1:0]  owner_inc;

    logic [NREQ-1:0] grant;
    logic [OWW-1:0]  grant_idx;

    logic            blocked;
    logic            in_hs;
    logic            out_hs;

    // Grant is decided in the same cycle the request shows up, so issue adds
    // no latency on top of the ALU's own.
    rr_arbiter #(
        .NREQ (NREQ),
        .OWW  (OWW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Reset and flush both silence every handshake in their cycle; flush
    // beating a coincident handshake falls out of this.
    assign blocked   = reset | flush;
    assign alu_flush = flush;

    // Result path is a pure pass-through; only resp_valid is steered.
    assign resp_result = alu_result;
    assign resp_flags  = alu_flags;

    // Operand mux from the current winner. Not registered: requesters hold
    // their fields stable until req_ready.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        alu_sub  = 1'b0;
        alu_sign = 1'b0;
        alu_arch = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == OWW'(i)) begin
                alu_a    = req_a[32*i +: 32];
                alu_b    = req_b[32*i +: 32];
                alu_ctrl = req_ctrl[4*i +: 4];
                alu_sub  = req_sub[i];
                alu_sign = req_sign[i];
                alu_arch = req_arch[i];
            end
        end
    end

    // Handshake steering. IDLE exposes the arbitration result to the ALU
    // input side; WAIT connects only the owner to the ALU output side.
    always_comb begin
        alu_in_valid  = 1'b0;
        req_ready     = '0;
        resp_valid    = '0;
        alu_out_ready = 1'b0;
        if (!blocked) begin
            if (state == IDLE) begin
                alu_in_valid = |req_valid;
                req_ready    = grant & {NREQ{alu_in_ready}};
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (owner == OWW'(i)) begin
                        resp_valid[i] = alu_out_valid;
                        alu_out_ready = resp_ready[i];
                    end
                end
            end
        end
    end

    assign in_hs  = alu_in_valid & alu_in_ready;
    assign out_hs = alu_out_valid & alu_out_ready;

    // Pointer moves to the requester after the one just served, wrapping
    // from NREQ-1 to 0 (NREQ need not be a power of two).
    assign owner_inc = (owner == OWW'(NREQ - 1)) ? '0 : owner + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation order cannot leak into behaviour.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else if (flush) begin
            // In-flight result is dropped; rr_ptr keeps its value.
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_hs) begin
                        owner <= grant_idx;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (out_hs) begin
                        state  <= IDLE;
                        rr_ptr <= owner_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule : alu_share_arbiter

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
// Directed bench for alu_share_arbiter with NREQ=2. A small behavioural ALU
// sits on the alu_* side (one-cycle latency, drops work on flush/reset).
// Stimulus pushes hand-computed expected responses into a queue; a separate
// monitor pops and compares on every resp_valid/resp_ready handshake.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int NREQ = 2;
    localparam int OWW  = 2;

    logic                 clock;
    logic                 reset;
    logic                 flush;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a;
    logic [NREQ*32-1:0]   req_b;
    logic [NREQ*4-1:0]    req_ctrl;
    logic [NREQ-1:0]      req_sub;
    logic [NREQ-1:0]      req_sign;
    logic [NREQ-1:0]      req_arch;
    logic [NREQ-1:0]      resp_valid;
    logic [NREQ-1:0]      resp_ready;
    logic [31:0]          resp_result;
    logic [3:0]           resp_flags;
    logic                 alu_in_valid;
    logic                 alu_in_ready;
    logic [31:0]          alu_a;
    logic [31:0]          alu_b;
    logic [3:0]           alu_ctrl;
    logic                 alu_sub;
    logic                 alu_sign;
    logic                 alu_arch;
    logic                 alu_out_valid;
    logic                 alu_out_ready;
    logic [31:0]          alu_result;
    logic [3:0]           alu_flags;
    logic                 alu_flush;

    typedef struct {
        int          owner;
        logic [31:0] result;
        logic [3:0]  flags;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    alu_share_arbiter #(
        .NREQ (NREQ),
        .OWW  (OWW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_ctrl      (req_ctrl),
        .req_sub       (req_sub),
        .req_sign      (req_sign),
        .req_arch      (req_arch),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_result   (resp_result),
        .resp_flags    (resp_flags),
        .alu_in_valid  (alu_in_valid),
        .alu_in_ready  (alu_in_ready),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_ctrl      (alu_ctrl),
        .alu_sub       (alu_sub),
        .alu_sign      (alu_sign),
        .alu_arch      (alu_arch),
        .alu_out_valid (alu_out_valid),
        .alu_out_ready (alu_out_ready),
        .alu_result    (alu_result),
        .alu_flags     (alu_flags),
        .alu_flush     (alu_flush)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] ctrl, input logic [31:0] a,
                           input logic [31:0] b, input logic sub, input logic sign,
                           input logic arch);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_ctrl[4*i +: 4] = ctrl;
        req_sub[i]   = sub;
        req_sign[i]  = sign;
        req_arch[i]  = arch;
        req_valid[i] = 1'b1;
    endtask

    task automatic expect_resp(input int owner, input logic [31:0] result, input logic [3:0] flags);
        exp_t e;
        e.owner  = owner;
        e.result = result;
        e.flags  = flags;
        sb.push_back(e);
    endtask

    // Waits (bounded) for requester i to be accepted; checks that it is the
    // only ready bit, then drops its valid right after the accepting edge.
    task automatic wait_accept(input int i, output int waited);
        bit ok;
        ok     = 1'b0;
        waited = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clock);
            if (req_ready[i]) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        check($sformatf("accept_req%0d", i), 32'(ok), 32'd1);
        if (ok) begin
            check($sformatf("ready_onehot_req%0d", i), 32'(req_ready), 32'(1 << i));
            check($sformatf("in_valid_req%0d", i), 32'(alu_in_valid), 32'd1);
        end
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            if (sb.size() == 0) break;
        end
        check("drain_scoreboard", 32'(sb.size()), 32'd0);
        tick();
    endtask

    // Reference ALU behaviour used by the bench-side ALU.
    function automatic void alu_calc(input logic [3:0] ctrl, input logic [31:0] a,
                                     input logic [31:0] b, input logic sub,
                                     input logic sign, input logic arch,
                                     output logic [31:0] r, output logic [3:0] f);
        logic [31:0] d;
        logic        lts;
        logic        ltu;
        logic        br;
        d   = a - b;
        lts = $signed(a) < $signed(b);
        ltu = a < b;
        br  = 1'b0;
        r   = '0;
        f   = '0;
        case (ctrl)
            ADD:   r = sub ? d : a + b;
            SLL:   r = a << b[4:0];
            SLTI:  r = {31'b0, lts};
            SLTIU: r = {31'b0, ltu};
            XOR:   r = a ^ b;
            SRI: begin
                if (arch) r = $unsigned($signed(a) >>> b[4:0]);
                else      r = a >> b[4:0];
            end
            OR:    r = a | b;
            AND:   r = a & b;
            BEQ:   br = (d == 0);
            BNE:   br = (d != 0);
            BLT:   br = sign ? lts : ltu;
            BGE:   br = sign ? !lts : !ltu;
            BLTU:  br = ltu;
            BGEU:  br = !ltu;
            default: r = '0;
        endcase
        if (ctrl[3]) begin
            r     = {31'b0, br};
            f[BR] = br;
            f[ZF] = (d == 0);
        end else begin
            f[ZF] = (r == 0);
        end
    endfunction

    // ------------------------------------------------------------------
    // Bench-side ALU: accepts one op, answers one cycle later, holds the
    // result until consumed, drops everything on flush or reset.
    // ------------------------------------------------------------------
    initial begin
        logic        s_in_hs;
        logic        s_out_hs;
        logic        s_kill;
        logic [31:0] r;
        logic [3:0]  f;
        alu_in_ready  = 1'b1;
        alu_out_valid = 1'b0;
        alu_result    = '0;
        alu_flags     = '0;
        r = '0;
        f = '0;
        forever begin
            @(negedge clock);
            s_in_hs  = alu_in_valid && alu_in_ready;
            s_out_hs = alu_out_valid && alu_out_ready;
            s_kill   = flush || reset;
            if (s_in_hs) alu_calc(alu_ctrl, alu_a, alu_b, alu_sub, alu_sign, alu_arch, r, f);
            @(posedge clock);
            #1;
            if (s_kill) begin
                alu_out_valid = 1'b0;
                alu_in_ready  = 1'b1;
            end else if (s_in_hs) begin
                alu_in_ready  = 1'b0;
                alu_out_valid = 1'b1;
                alu_result    = r;
                alu_flags     = f;
            end else if (s_out_hs) begin
                alu_out_valid = 1'b0;
                alu_in_ready  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compare every delivered response against the scoreboard.
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        int   who;
        forever begin
            @(negedge clock);
            if ((resp_valid & resp_ready) != '0) begin
                who = -1;
                for (int i = 0; i < NREQ; i++) if (resp_valid[i]) who = i;
                check("resp_valid_onehot", 32'($countones(resp_valid)), 32'd1);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL resp_unexpected: owner %0d result 0x%0h, expected no response",
                             who, resp_result);
                end else begin
                    e = sb.pop_front();
                    check("resp_owner", 32'(who), 32'(e.owner));
                    check("resp_result", resp_result, e.result);
                    check("resp_flags", 32'(resp_flags), 32'(e.flags));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        int w;
        reset      = 1'b1;
        flush      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_ctrl   = '0;
        req_sub    = '0;
        req_sign   = '0;
        req_arch   = '0;
        resp_ready = '1;

        // Reset: a pending request must not be accepted while reset is high.
        set_req(0, ADD, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_alu_in_valid", 32'(alu_in_valid), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_alu_out_ready", 32'(alu_out_ready), 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check("rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        check("rst_owner", 32'(dut.owner), 32'd0);
        tick();
        reset = 1'b0;

        // Single requester: ADD 5+7, accepted in the same cycle.
        expect_resp(0, 32'd12, 4'b0000);
        wait_accept(0, w);
        check("single_zero_latency", 32'(w), 32'd0);
        drain();
        check("single_rr_ptr", 32'(dut.rr_ptr), 32'd1);

        // Branch flags on requester 1 (brings rr_ptr back to 0).
        set_req(1, BEQ, 32'd9, 32'd9, 1'b1, 1'b0, 1'b0);
        expect_resp(1, 32'd1, 4'b1100);
        wait_accept(1, w);
        drain();
        set_req(1, BLT, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 1'b0);
        expect_resp(1, 32'd1, 4'b1000);
        wait_accept(1, w);
        drain();

        // Contention: both valid, rr_ptr=0 -> req0 first, then req1.
        set_req(0, ADD, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
        set_req(1, XOR, 32'h0000_00F0, 32'h0000_000F, 1'b0, 1'b0, 1'b0);
        expect_resp(0, 32'd3, 4'b0000);
        expect_resp(1, 32'h0000_00FF, 4'b0000);
        wait_accept(0, w);
        check("contention_req0_first", 32'(w), 32'd0);
        wait_accept(1, w);
        drain();
        check("contention_rr_wrap", 32'(dut.rr_ptr), 32'd0);

        // Back-pressure: owner not ready for 5 cycles, req1 waiting meanwhile.
        resp_ready = 2'b10;
        set_req(0, ADD, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0);
        expect_resp(0, 32'd12, 4'b0000);
        wait_accept(0, w);
        set_req(1, ADD, 32'd10, 32'd3, 1'b1, 1'b0, 1'b0);
        expect_resp(1, 32'd7, 4'b0000);
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            check("bp_alu_out_ready", 32'(alu_out_ready), 32'd0);
            check("bp_resp_valid", 32'(resp_valid), 32'b01);
            check("bp_resp_result", resp_result, 32'd12);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_alu_in_valid", 32'(alu_in_valid), 32'd0);
        end
        tick();
        resp_ready = 2'b11;
        wait_accept(1, w);
        drain();

        // Flush on the cycle the result appears; new work waits behind it.
        set_req(0, ADD, 32'd2, 32'd2, 1'b0, 1'b0, 1'b0);
        wait_accept(0, w);
        flush = 1'b1;
        set_req(0, ADD, 32'd100, 32'd1, 1'b0, 1'b0, 1'b0);
        set_req(1, OR, 32'h0000_0F00, 32'h0000_00F0, 1'b0, 1'b0, 1'b0);
        expect_resp(0, 32'd101, 4'b0000);
        expect_resp(1, 32'h0000_0FF0, 4'b0000);
        @(negedge clock);
        check("flush_alu_flush", 32'(alu_flush), 32'd1);
        check("flush_resp_valid", 32'(resp_valid), 32'd0);
        check("flush_alu_out_ready", 32'(alu_out_ready), 32'd0);
        check("flush_alu_in_valid", 32'(alu_in_valid), 32'd0);
        check("flush_req_ready", 32'(req_ready), 32'd0);
        tick();
        flush = 1'b0;
        check("flush_rr_ptr_kept", 32'(dut.rr_ptr), 32'd0);
        check("flush_state_idle", 32'(dut.state), 32'(IDLE));
        wait_accept(0, w);
        check("flush_next_req0_first", 32'(w), 32'd0);
        wait_accept(1, w);
        drain();

        // Move rr_ptr to 1, then reset in the middle of an operation.
        set_req(0, ADD, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        expect_resp(0, 32'd2, 4'b0000);
        wait_accept(0, w);
        drain();
        set_req(0, ADD, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0);
        wait_accept(0, w);
        reset = 1'b1;
        set_req(1, SLL, 32'd1, 32'd4, 1'b0, 1'b0, 1'b0);
        expect_resp(1, 32'd16, 4'b0000);
        @(negedge clock);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_alu_in_valid", 32'(alu_in_valid), 32'd0);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_alu_out_ready", 32'(alu_out_ready), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        check("midrst_state_idle", 32'(dut.state), 32'(IDLE));
        check("midrst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        wait_accept(1, w);
        check("midrst_req1_zero_latency", 32'(w), 32'd0);
        drain();

        check("final_scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_alu_share_arbiter
